// File: rtl/peri_write_if.sv
// Peripheral write port plus the drained external bus, bundled for the write sink.
// The slave modport is the sink's view; master is the environment driving it.
interface peri_write_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              peri_web;
    logic [ADDR_W-1:0] peri_addr;
    logic [DATA_W-1:0] peri_datao;
    logic              ext_valid;
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_data;
    logic              ext_ready;

    modport slave (
        input  peri_web, peri_addr, peri_datao, ext_ready,
        output ext_valid, ext_addr, ext_data
    );

    modport master (
        output peri_web, peri_addr, peri_datao, ext_ready,
        input  ext_valid, ext_addr, ext_data
    );
endinterface

// File: rtl/peri_write_sink.sv
// Captures every write from a non-stallable peripheral port into a FIFO and drains
// it one entry at a time through a registered valid/ready output stage.
module peri_write_sink #(
    parameter  int DEPTH  = 8,
    parameter  int ADDR_W = 16,
    parameter  int DATA_W = 16,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    peri_write_if.slave      bus,
    input  logic             clr_err,
    output logic [CNT_W-1:0] fifo_count,
    output logic             busy,
    output logic             overflow,
    output logic             addr_err
);

    localparam int               PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

    typedef enum logic {IDLE, SEND} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    state_t           state_q;
    logic             ext_valid_q;
    entry_t           held_q;
    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             addr_err_q, addr_err_d;

    logic fifo_empty;
    logic addr_ok;
    logic push_req;
    logic addr_bad;
    logic pop;
    logic push;

    // Page 0x00xx is reserved; writes there never reach the FIFO.
    assign addr_ok    = bus.peri_addr[15:8] != 8'h00;
    assign push_req   = !bus.peri_web && addr_ok;
    assign addr_bad   = !bus.peri_web && !addr_ok;
    assign fifo_empty = count_q == '0;

    // A pop frees a slot on the same edge, so a full FIFO still accepts a write then.
    assign pop  = !fifo_empty && (state_q == IDLE || bus.ext_ready);
    assign push = push_req && (count_q != FULL || pop);

    // NOTE: every variable gets a default at the top of always_comb so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        wr_ptr_d   = wr_ptr_q + PTR_W'(push);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        count_d    = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        overflow_d = (overflow_q && !clr_err) || (push_req && !push);
        addr_err_d = (addr_err_q && !clr_err) || addr_bad;
    end

    // NOTE: sequential state is always updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            addr_err_q <= addr_err_d;
        end
    end

    // NOTE: the storage array has no reset; the pointers and count already mark
    // every entry invalid, so resetting the data would only cost flops.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{addr: bus.peri_addr, data: bus.peri_datao};
        end
    end

    // Drain FSM: the output register is loaded only from the FIFO head, never bypassed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ext_valid_q <= 1'b0;
            held_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        held_q      <= mem_q[rd_ptr_q];
                        ext_valid_q <= 1'b1;
                        state_q     <= SEND;
                    end
                end
                SEND: begin
                    if (bus.ext_ready) begin
                        if (pop) begin
                            held_q <= mem_q[rd_ptr_q];
                        end else begin
                            ext_valid_q <= 1'b0;
                            state_q     <= IDLE;
                        end
                    end
                end
                default: begin
                    ext_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.ext_valid = ext_valid_q;
    assign bus.ext_addr  = held_q.addr;
    assign bus.ext_data  = held_q.data;
    assign fifo_count    = count_q;
    assign busy          = ext_valid_q || !fifo_empty;
    assign overflow      = overflow_q;
    assign addr_err      = addr_err_q;

endmodule

// File: tb/tb_peri_write_sink.sv
// Scoreboard bench for peri_write_sink: accepted writes are queued as expectations,
// a negedge monitor compares every handshake and status output against a queue model.
module tb_peri_write_sink;

    localparam int DEPTH = 8;

    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       clr_err = 1'b0;
    logic [3:0] fifo_count;
    logic       busy;
    logic       overflow;
    logic       addr_err;

    peri_write_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    peri_write_sink #(.DEPTH(DEPTH), .ADDR_W(16), .DATA_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .clr_err    (clr_err),
        .fifo_count (fifo_count),
        .busy       (busy),
        .overflow   (overflow),
        .addr_err   (addr_err)
    );

    always #5 clk = ~clk;

    int  total = 0;
    int  bad   = 0;
    wr_t exp_q[$];

    // Reference state: writes waiting behind the output stage, and whether one is held.
    int  m_cnt  = 0;
    bit  m_held = 1'b0;
    bit  m_ovf  = 1'b0;
    bit  m_aerr = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_clear();
        m_cnt  = 0;
        m_held = 1'b0;
        m_ovf  = 1'b0;
        m_aerr = 1'b0;
        exp_q.delete();
    endtask

    // Applies the behavioural rules to the inputs present at this clock edge.
    task automatic model_step();
        bit legal, illegal, take_next, accept;
        legal     = !bus.peri_web && bus.peri_addr[15:8] != 8'h00;
        illegal   = !bus.peri_web && bus.peri_addr[15:8] == 8'h00;
        take_next = m_cnt > 0 && (!m_held || bus.ext_ready);
        accept    = legal && (m_cnt < DEPTH || take_next);
        if (take_next) begin
            m_cnt--;
            m_held = 1'b1;
        end else if (m_held && bus.ext_ready) begin
            m_held = 1'b0;
        end
        if (accept) begin
            m_cnt++;
            exp_q.push_back('{a: bus.peri_addr, d: bus.peri_datao});
        end
        m_ovf  = (m_ovf && !clr_err) || (legal && !accept);
        m_aerr = (m_aerr && !clr_err) || illegal;
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    task automatic set_in(input logic web, input logic [15:0] a, input logic [15:0] d,
                          input logic rdy, input logic clr);
        bus.peri_web   = web;
        bus.peri_addr  = a;
        bus.peri_datao = d;
        bus.ext_ready  = rdy;
        clr_err        = clr;
    endtask

    task automatic do_reset();
        set_in(1'b1, 16'h0, 16'h0, 1'b0, 1'b0);
        rst_n = 1'b0;
        model_clear();
        #1;
        check("rst_ext_valid", bus.ext_valid, 0);
        check("rst_ext_addr", bus.ext_addr, 0);
        check("rst_count", fifo_count, 0);
        check("rst_busy", busy, 0);
        check("rst_flags", {overflow, addr_err}, 0);
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    // Monitor: compares outputs to the model and retires a write at each handshake.
    always @(negedge clk) begin
        check("ext_valid", bus.ext_valid, m_held);
        check("fifo_count", fifo_count, m_cnt);
        check("busy", busy, m_held || m_cnt != 0);
        check("overflow", overflow, m_ovf);
        check("addr_err", addr_err, m_aerr);
        if (bus.ext_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got %h/%h want none (t=%0t)",
                         bus.ext_addr, bus.ext_data, $time);
            end else begin
                check("ext_addr", bus.ext_addr, exp_q[0].a);
                check("ext_data", bus.ext_data, exp_q[0].d);
                if (bus.ext_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        set_in(1'b1, 16'h0, 16'h0, 1'b0, 1'b0);
        #1;
        do_reset();

        // Single write: visible after the second edge, for one cycle.
        set_in(1'b0, 16'h0120, 16'hBEEF, 1'b1, 1'b0);
        step();
        check("t1_e0_valid", bus.ext_valid, 0);
        bus.peri_web = 1'b1;
        step();
        check("t1_e1_valid", bus.ext_valid, 1);
        check("t1_e1_addr", bus.ext_addr, 16'h0120);
        check("t1_e1_data", bus.ext_data, 16'hBEEF);
        step();
        check("t1_e2_valid", bus.ext_valid, 0);

        // Burst of eight with the bus stalled, then released.
        for (int i = 0; i < 8; i++) begin
            set_in(1'b0, 16'h0100 + 16'(i), 16'(i), 1'b0, 1'b0);
            step();
        end
        check("t2_count", fifo_count, 7);
        check("t2_held", {bus.ext_valid, bus.ext_addr, bus.ext_data}, {1'b1, 16'h0100, 16'h0000});
        set_in(1'b1, 16'h0, 16'h0, 1'b1, 1'b0);
        repeat (8) step();
        check("t2_busy", busy, 0);

        // Overflow: ten writes into a stalled sink, the tenth is dropped.
        for (int i = 0; i < 10; i++) begin
            set_in(1'b0, 16'h0200 + 16'(i), 16'h0100 + 16'(i), 1'b0, 1'b0);
            step();
        end
        check("t3_count", fifo_count, 8);
        check("t3_overflow", overflow, 1);
        set_in(1'b1, 16'h0, 16'h0, 1'b0, 1'b1);
        step();
        check("t3_clr", overflow, 0);

        // Full FIFO, pop and push on the same edge.
        set_in(1'b0, 16'h0300, 16'h3333, 1'b1, 1'b0);
        step();
        check("t4_count", fifo_count, 8);
        check("t4_overflow", overflow, 0);
        set_in(1'b1, 16'h0, 16'h0, 1'b1, 1'b0);
        repeat (12) step();
        check("t4_busy", busy, 0);

        // Reserved page write, then set colliding with clear.
        set_in(1'b0, 16'h00FF, 16'h1234, 1'b1, 1'b0);
        step();
        check("t5_addr_err", addr_err, 1);
        check("t5_untouched", {bus.ext_valid, fifo_count}, 0);
        set_in(1'b0, 16'h00AB, 16'h5678, 1'b1, 1'b1);
        step();
        check("t5_set_wins", addr_err, 1);
        set_in(1'b1, 16'h0, 16'h0, 1'b1, 1'b1);
        step();
        check("t5_cleared", addr_err, 0);

        // Reset with one held and five queued; nothing stale may reappear.
        for (int i = 0; i < 6; i++) begin
            set_in(1'b0, 16'h0400 + 16'(i), 16'hA000 + 16'(i), 1'b0, 1'b0);
            step();
        end
        check("t6_pre_count", fifo_count, 5);
        check("t6_pre_valid", bus.ext_valid, 1);
        do_reset();
        set_in(1'b1, 16'h0, 16'h0, 1'b1, 1'b0);
        repeat (6) step();

        // Randomized traffic; stall-heavy and flow-heavy halves.
        for (int i = 0; i < 2000; i++) begin
            logic [7:0] hi;
            hi = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            set_in(1'($urandom_range(0, 1)), {hi, 8'($urandom)}, 16'($urandom),
                   (i < 1000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                   $urandom_range(0, 15) == 0);
            step();
        end
        set_in(1'b1, 16'h0, 16'h0, 1'b1, 1'b0);
        repeat (DEPTH + 4) step();
        check("final_drained", exp_q.size(), 0);
        check("final_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
